data_cache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the MEM stage and main memory.

---
 rtl/data_cache_ctrl_if.sv | 27 ++
 rtl/data_cache_ctrl.sv | 160 ++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/data_cache_ctrl_if.sv
// Bundle between the data cache, the MEM-stage pipeline and main memory.
// The cache takes the slave view; the pipeline and memory side drive through master.
interface data_cache_ctrl_if;
   logic         read;
   logic         write;
   logic [2:0]   func3;
   logic [31:0]  address;
   logic [31:0]  writedata;
   logic [31:0]  readdata;
   logic         busywait;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_address;
   logic [127:0] mem_writedata;
   logic [127:0] mem_readdata;
   logic         mem_busywait;

   modport slave (
      input  read, write, func3, address, writedata, mem_readdata, mem_busywait,
      output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
   );

   modport master (
      output read, write, func3, address, writedata, mem_readdata, mem_busywait,
      input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
   );
endinterface

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// Hits complete in the request cycle; misses stall through write-back, fill and update.
module data_cache_ctrl #(
   parameter int INDEX_BITS = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   data_cache_ctrl_if.slave  bus
);
   localparam int TAG_BITS = 28 - INDEX_BITS;
   localparam int LINES    = 1 << INDEX_BITS;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

   state_t                 state_q, state_d;
   logic [LINES-1:0]       valid_q, dirty_q;
   logic [TAG_BITS-1:0]    tag_q  [LINES];
   logic [127:0]           data_q [LINES];
   logic [TAG_BITS-1:0]    miss_tag_q;
   logic [INDEX_BITS-1:0]  miss_index_q;
   logic [127:0]           fill_q;

   logic [TAG_BITS-1:0]    req_tag;
   logic [INDEX_BITS-1:0]  req_index;
   logic [1:0]             req_word;
   logic [1:0]             req_byte;
   logic                   req;
   logic                   hit;
   logic [127:0]           line_rd;
   logic [31:0]            sel_word;
   logic [1:0]             lane_off;
   logic [3:0]             byte_en;
   logic [31:0]            wdata_shifted;
   logic [31:0]            merged_word;
   logic                   hit_write;
   logic                   miss_start;
   logic                   busy;
   logic [31:0]            rdata;
   logic                   unused_func3;

   assign req_tag      = bus.address[31:4+INDEX_BITS];
   assign req_index    = bus.address[3+INDEX_BITS:4];
   assign req_word     = bus.address[3:2];
   assign req_byte     = bus.address[1:0];
   assign req          = bus.read | bus.write;
   assign unused_func3 = bus.func3[2];

   assign line_rd  = data_q[req_index];
   assign sel_word = line_rd[{req_word, 5'b00000} +: 32];
   assign hit      = valid_q[req_index] && (tag_q[req_index] == req_tag);

   // Misaligned halves and words are forced down to their natural boundary.
   always_comb begin
      lane_off = 2'b00;
      byte_en  = 4'b1111;
      case (bus.func3[1:0])
         2'b00: begin
            lane_off = req_byte;
            byte_en  = 4'b0001 << req_byte;
         end
         2'b01: begin
            lane_off = {req_byte[1], 1'b0};
            byte_en  = 4'b0011 << {req_byte[1], 1'b0};
         end
         default: begin
            lane_off = 2'b00;
            byte_en  = 4'b1111;
         end
      endcase
   end

   assign wdata_shifted = bus.writedata << {lane_off, 3'b000};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign merged_word[8*gi +: 8] = byte_en[gi] ? wdata_shifted[8*gi +: 8]
                                                     : sel_word[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      busy       = 1'b0;
      rdata      = 32'd0;
      hit_write  = 1'b0;
      miss_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  rdata     = sel_word >> {lane_off, 3'b000};
                  hit_write = bus.write;
               end else begin
                  busy       = 1'b1;
                  miss_start = 1'b1;
                  state_d    = (valid_q[req_index] && dirty_q[req_index]) ? WRITEBACK
                                                                           : ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            busy = 1'b1;
            if (!bus.mem_busywait) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            busy = 1'b1;
            if (!bus.mem_busywait) state_d = UPDATE;
         end
         UPDATE: begin
            busy    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         dirty_q      <= '0;
         miss_tag_q   <= '0;
         miss_index_q <= '0;
      end else begin
         state_q <= state_d;
         if (miss_start) begin
            miss_tag_q   <= req_tag;
            miss_index_q <= req_index;
         end
         if (state_q == UPDATE) begin
            valid_q[miss_index_q] <= 1'b1;
            dirty_q[miss_index_q] <= 1'b0;
         end else if (hit_write) begin
            dirty_q[req_index] <= 1'b1;
         end
      end
   end

   // Line storage carries no reset; a reset edge simply suppresses any pending update.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         if (state_q == ALLOCATE && !bus.mem_busywait) fill_q <= bus.mem_readdata;
         if (state_q == UPDATE) begin
            data_q[miss_index_q] <= fill_q;
            tag_q[miss_index_q]  <= miss_tag_q;
         end else if (hit_write) begin
            data_q[req_index][{req_word, 5'b00000} +: 32] <= merged_word;
         end
      end
   end

   assign bus.busywait      = busy;
   assign bus.readdata      = rdata;
   assign bus.mem_read      = (state_q == ALLOCATE);
   assign bus.mem_write     = (state_q == WRITEBACK);
   assign bus.mem_address   = (state_q == WRITEBACK) ? {tag_q[miss_index_q], miss_index_q} :
                              (state_q == ALLOCATE)  ? {miss_tag_q, miss_index_q}         :
                                                       28'd0;
   assign bus.mem_writedata = (state_q == WRITEBACK) ? data_q[miss_index_q] : 128'd0;
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl with a fixed-latency line memory model.
module tb_data_cache_ctrl;
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam int         LAT = 2;

   logic CLK;
   logic RESET;
   data_cache_ctrl_if bus ();

   data_cache_ctrl #(.INDEX_BITS(3)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [127:0] mem_model [16];
   int           lat_cnt = 0;

   assign bus.mem_busywait = (bus.mem_read | bus.mem_write) && (lat_cnt != LAT);
   assign bus.mem_readdata = mem_model[bus.mem_address[3:0]];

   always @(posedge CLK) begin
      if ((bus.mem_read | bus.mem_write) && bus.mem_busywait) lat_cnt <= lat_cnt + 1;
      else lat_cnt <= 0;
      if (bus.mem_write && !bus.mem_busywait) mem_model[bus.mem_address[3:0]] = bus.mem_writedata;
   end

   int           n_pass  = 0;
   int           n_total = 0;
   logic         rd_log   [40];
   logic         wr_log   [40];
   logic [27:0]  addr_log [40];
   logic [127:0] wd_log   [40];
   logic         both_seen;
   int           cyc;

   localparam logic [127:0] MERGED = {32'h33333333, 32'h22222222, 32'h76543210, 32'hDDCC5AAA};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
      @(negedge CLK);
      bus.read      = rd;
      bus.write     = wr;
      bus.func3     = f3;
      bus.address   = a;
      bus.writedata = wd;
      #2;
      $display("txn rd=%0b wr=%0b f3=%b addr=%h wdata=%h busywait=%0b readdata=%h",
               rd, wr, f3, a, wd, bus.busywait, bus.readdata);
   endtask

   task automatic run_miss(output int cycles);
      cycles    = 0;
      both_seen = 1'b0;
      while (bus.busywait === 1'b1 && cycles < 40) begin
         rd_log[cycles]   = bus.mem_read;
         wr_log[cycles]   = bus.mem_write;
         addr_log[cycles] = bus.mem_address;
         wd_log[cycles]   = bus.mem_writedata;
         if (bus.mem_read && bus.mem_write) both_seen = 1'b1;
         @(negedge CLK);
         #2;
         cycles++;
      end
   endtask

   initial begin
      RESET         = 1'b1;
      bus.read      = 1'b0;
      bus.write     = 1'b0;
      bus.func3     = 3'b000;
      bus.address   = 32'd0;
      bus.writedata = 32'd0;
      for (int i = 0; i < 16; i++) mem_model[i] = 128'd0;
      mem_model[4]  = {32'h33333333, 32'h22222222, 32'h76543210, 32'hDDCCBBAA};
      mem_model[8]  = {32'h88880003, 32'h88880002, 32'h88880001, 32'hCAFE0080};
      mem_model[12] = {32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001, 32'h80011234};

      repeat (2) @(negedge CLK);
      #2;
      chk("rst_busywait",  128'(bus.busywait),      128'd0);
      chk("rst_mem_read",  128'(bus.mem_read),      128'd0);
      chk("rst_mem_write", 128'(bus.mem_write),     128'd0);
      chk("rst_mem_addr",  128'(bus.mem_address),   128'd0);
      chk("rst_mem_wdata", bus.mem_writedata,       128'd0);
      chk("rst_readdata",  128'(bus.readdata),      128'd0);
      @(negedge CLK);
      RESET = 1'b0;

      // Cold miss on 0x40 and fill
      req(1'b1, 1'b0, LW, 32'h40, 32'd0);
      chk("t1_miss_busy",  128'(bus.busywait), 128'd1);
      chk("t1_idle_nord",  128'(bus.mem_read), 128'd0);
      run_miss(cyc);
      chk("t1_latency",    128'(cyc),          128'd5);
      chk("t1_alloc_rd",   128'(rd_log[1]),    128'd1);
      chk("t1_alloc_addr", 128'(addr_log[1]),  128'h4);
      chk("t1_hit_data",   128'(bus.readdata), 128'hDDCCBBAA);

      // Store byte hit then reload
      req(1'b0, 1'b1, LB, 32'h41, 32'h0000005A);
      chk("t2_sb_busy",    128'(bus.busywait), 128'd0);
      req(1'b1, 1'b0, LW, 32'h40, 32'd0);
      chk("t2_lw_data",    128'(bus.readdata), 128'hDDCC5AAA);
      chk("t2_lw_busy",    128'(bus.busywait), 128'd0);
      chk("t2_no_mrd",     128'(bus.mem_read), 128'd0);
      chk("t2_no_mwr",     128'(bus.mem_write), 128'd0);

      // Conflict miss evicts the dirty line
      req(1'b1, 1'b0, LW, 32'hC0, 32'd0);
      chk("t3_miss_busy",  128'(bus.busywait), 128'd1);
      run_miss(cyc);
      chk("t3_latency",    128'(cyc),          128'd8);
      chk("t3_wb_wr",      128'(wr_log[1]),    128'd1);
      chk("t3_wb_nord",    128'(rd_log[1]),    128'd0);
      chk("t3_wb_addr",    128'(addr_log[1]),  128'h4);
      chk("t3_wb_data",    wd_log[1],          MERGED);
      chk("t3_wb_hold",    128'(wr_log[3]),    128'd1);
      chk("t3_al_rd",      128'(rd_log[4]),    128'd1);
      chk("t3_al_nowr",    128'(wr_log[4]),    128'd0);
      chk("t3_al_addr",    128'(addr_log[4]),  128'hC);
      chk("t3_never_both", 128'(both_seen),    128'd0);
      chk("t3_mem_line",   mem_model[4],       MERGED);
      chk("t3_hit_data",   128'(bus.readdata), 128'h80011234);

      // Sub-word loads
      req(1'b1, 1'b0, LH, 32'hC2, 32'd0);
      chk("t4_lh",         128'(bus.readdata[15:0]), 128'h8001);
      req(1'b1, 1'b0, LBU, 32'hC3, 32'd0);
      chk("t4_lbu",        128'(bus.readdata[7:0]),  128'h80);
      req(1'b1, 1'b0, LW, 32'hC3, 32'd0);
      chk("t4_lw_misal",   128'(bus.readdata),       128'h80011234);
      chk("t4_busy",       128'(bus.busywait),       128'd0);

      // Reset during ALLOCATE
      req(1'b1, 1'b0, LW, 32'h80, 32'd0);
      chk("t5_miss_busy",  128'(bus.busywait), 128'd1);
      @(negedge CLK);
      #2;
      chk("t5_in_alloc",   128'(bus.mem_read), 128'd1);
      @(negedge CLK);
      RESET    = 1'b1;
      bus.read = 1'b0;
      @(negedge CLK);
      #2;
      chk("t5_rst_mrd",    128'(bus.mem_read),  128'd0);
      chk("t5_rst_mwr",    128'(bus.mem_write), 128'd0);
      chk("t5_rst_busy",   128'(bus.busywait),  128'd0);
      RESET = 1'b0;
      req(1'b1, 1'b0, LW, 32'h80, 32'd0);
      chk("t5_remiss",     128'(bus.busywait),  128'd1);
      run_miss(cyc);
      chk("t5_latency",    128'(cyc),           128'd5);
      chk("t5_hit_data",   128'(bus.readdata),  128'hCAFE0080);

      // Misaligned store half allocates then merges lanes 2,3
      req(1'b0, 1'b1, LH, 32'h47, 32'h0000BEEF);
      chk("t6_miss_busy",  128'(bus.busywait), 128'd1);
      run_miss(cyc);
      chk("t6_latency",    128'(cyc),          128'd5);
      req(1'b1, 1'b0, LW, 32'h44, 32'd0);
      chk("t6_lw44",       128'(bus.readdata), 128'hBEEF3210);
      req(1'b1, 1'b0, LW, 32'h40, 32'd0);
      chk("t6_lw40",       128'(bus.readdata), 128'hDDCC5AAA);

      @(negedge CLK);
      bus.read = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
